// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU scheduler: op codes, FSM states, width helper.
package alu_sched_pkg;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_ADDI = 3'b010;
  localparam logic [2:0] ALU_MUL  = 3'b011;
  localparam logic [2:0] ALU_SRAI = 3'b100;
  localparam logic [2:0] ALU_SLL  = 3'b101;
  localparam logic [2:0] ALU_XOR  = 3'b110;
  localparam logic [2:0] ALU_SUB  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    RESP = 2'd3
  } state_t;

  // Number of bits needed to index WIDTH positions (WIDTH is a power of two).
  function automatic int unsigned log2_width(input int unsigned w);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < w) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle over WIDTH cycles.
module alu_mul_iter
  import alu_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CW = log2_width(WIDTH);

  logic             running;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;

  // Product presented is the accumulator after the current iteration, so the
  // final value is usable in the same cycle done is raised.
  always_comb begin
    product = acc + (mplier[0] ? mcand : '0);
    done    = running && (count == CW'(WIDTH - 1));
  end

  // Load operands on start, then step one multiplier bit per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      count   <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else if (start) begin
      running <= 1'b1;
      count   <= '0;
      acc     <= '0;
      mcand   <= a;
      mplier  <= b;
    end else if (running) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// Round-robin sharing of one ALU between two requesters, sequencing each op
// through execute (or iterative multiply) and a held response.
module alu_scheduler
  import alu_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [1:0]         req_valid_i,
  output logic [1:0]         req_ready_o,
  input  logic [5:0]         req_op_i,
  input  logic [2*WIDTH-1:0] req_a_i,
  input  logic [2*WIDTH-1:0] req_b_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic               rsp_id_o,
  output logic [WIDTH-1:0]   rsp_data_o,
  output logic               busy_o
);

  localparam int unsigned SHW = log2_width(WIDTH);

  state_t           state;
  logic             last_grant;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;
  logic [WIDTH-1:0] res_q;

  logic             grant_any;
  logic             gid;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] exec_res;
  logic [SHW-1:0]   shamt;

  // Arbitration and payload selection; ready is also held low while in reset
  // so every output reads zero during reset.
  always_comb begin
    grant_any = rst_i && (state == IDLE) && (req_valid_i != 2'b00);
    gid       = 1'b0;
    if (req_valid_i == 2'b10)      gid = 1'b1;
    else if (req_valid_i == 2'b11) gid = ~last_grant;
    req_ready_o = '0;
    if (grant_any) req_ready_o[gid] = 1'b1;
    sel_op    = gid ? req_op_i[5:3] : req_op_i[2:0];
    sel_a     = gid ? req_a_i[2*WIDTH-1:WIDTH] : req_a_i[WIDTH-1:0];
    sel_b     = gid ? req_b_i[2*WIDTH-1:WIDTH] : req_b_i[WIDTH-1:0];
    mul_start = grant_any && (sel_op == ALU_MUL);
  end

  // Single-cycle result mux over the latched operands.
  always_comb begin
    shamt    = b_q[SHW-1:0];
    exec_res = '0;
    case (op_q)
      ALU_AND:  exec_res = a_q & b_q;
      ALU_ADD:  exec_res = a_q + b_q;
      ALU_ADDI: exec_res = a_q + b_q;
      ALU_SRAI: exec_res = $signed(a_q) >>> shamt;
      ALU_SLL:  exec_res = a_q << shamt;
      ALU_XOR:  exec_res = a_q ^ b_q;
      ALU_SUB:  exec_res = a_q - b_q;
      default:  exec_res = '0;
    endcase
  end

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .start  (mul_start),
    .a      (sel_a),
    .b      (sel_b),
    .done   (mul_done),
    .product(mul_product)
  );

  // Scheduler FSM: grant, execute or multiply, then hold the response.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      res_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            op_q       <= sel_op;
            a_q        <= sel_a;
            b_q        <= sel_b;
            id_q       <= gid;
            last_grant <= gid;
            state      <= (sel_op == ALU_MUL) ? MUL : EXEC;
          end
        end
        EXEC: begin
          res_q <= exec_res;
          state <= RESP;
        end
        MUL: begin
          if (mul_done) begin
            res_q <= mul_product;
            state <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_valid_o = (state == RESP);
  assign busy_o      = (state != IDLE);
  assign rsp_id_o    = id_q;
  assign rsp_data_o  = res_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Scoreboard bench for alu_scheduler: expected responses are queued at grant
// time and compared (data, owner, arrival cycle) when the response appears.
module tb_alu_scheduler;

  localparam int W = 32;

  logic          clk_i;
  logic          rst_i;
  logic [1:0]    req_valid_i;
  logic [1:0]    req_ready_o;
  logic [5:0]    req_op_i;
  logic [2*W-1:0] req_a_i;
  logic [2*W-1:0] req_b_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic          rsp_id_o;
  logic [W-1:0]  rsp_data_o;
  logic          busy_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [W:0] sb_q[$];
  int         sb_t[$];

  alu_scheduler #(.WIDTH(W)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_op_i   (req_op_i),
    .req_a_i    (req_a_i),
    .req_b_i    (req_b_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_id_o   (rsp_id_o),
    .rsp_data_o (rsp_data_o),
    .busy_o     (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic signed [W-1:0] sa;
    logic [W-1:0] r;
    sa = a;
    case (op)
      3'b000:  r = a & b;
      3'b001:  r = a + b;
      3'b010:  r = a + b;
      3'b011:  r = a * b;
      3'b100:  r = sa >>> b[4:0];
      3'b101:  r = a << b[4:0];
      3'b110:  r = a ^ b;
      default: r = a - b;
    endcase
    return r;
  endfunction

  task automatic drive_req(input int r, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b);
    req_op_i[r*3 +: 3] = op;
    req_a_i[r*W +: W]  = a;
    req_b_i[r*W +: W]  = b;
    req_valid_i[r]     = 1'b1;
  endtask

  task automatic do_reset();
    rst_i       = 1'b0;
    req_valid_i = 2'b00;
    rsp_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask

  // Wait (bounded) for a grant; queue the expected response of the winner.
  task automatic grant_one(output int w, output int t);
    logic [2:0]   op;
    logic [W-1:0] a, b;
    int lat;
    w = -1;
    t = -1;
    for (int n = 0; n < 100; n++) begin
      #1;
      if (req_ready_o != 2'b00) break;
      @(negedge clk_i);
    end
    checks++;
    if (req_ready_o != 2'b01 && req_ready_o != 2'b10) begin
      failures++;
      $display("FAIL grant: req_ready_o=%b, required exactly one bit set", req_ready_o);
      return;
    end
    w   = req_ready_o[1] ? 1 : 0;
    t   = cyc;
    op  = req_op_i[w*3 +: 3];
    a   = req_a_i[w*W +: W];
    b   = req_b_i[w*W +: W];
    lat = (op == 3'b011) ? W + 1 : 2;
    sb_q.push_back({w[0], model(op, a, b)});
    sb_t.push_back(t + lat);
    @(negedge clk_i);
    req_valid_i[w] = 1'b0;
  endtask

  // Wait (bounded) for a response and compare against the scoreboard head.
  task automatic get_rsp();
    logic [W:0] e;
    int et;
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      #1;
      if (rsp_valid_o) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    checks++;
    if (!seen || sb_q.size() == 0) begin
      failures++;
      $display("FAIL rsp_wait: seen=%0d queued=%0d, required a response to an issued op",
               seen, sb_q.size());
      return;
    end
    e  = sb_q.pop_front();
    et = sb_t.pop_front();
    checks++;
    if (rsp_data_o !== e[W-1:0]) begin
      failures++;
      $display("FAIL rsp_data: got %h required %h", rsp_data_o, e[W-1:0]);
    end
    checks++;
    if (rsp_id_o !== e[W]) begin
      failures++;
      $display("FAIL rsp_id: got %0d required %0d", rsp_id_o, e[W]);
    end
    checks++;
    if (cyc !== et) begin
      failures++;
      $display("FAIL rsp_cycle: got %0d required %0d", cyc, et);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({req_ready_o, rsp_valid_o, rsp_id_o, busy_o} !== 5'b0 || rsp_data_o !== '0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b valid=%b id=%b busy=%b data=%h, required all 0",
               req_ready_o, rsp_valid_o, rsp_id_o, busy_o, rsp_data_o);
    end
  endtask

  task automatic test_add();
    int w, t;
    drive_req(0, 3'b001, 32'hFFFF_FFFF, 32'h1);
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL add_busy_grant: got %b required 0", busy_o);
    end
    grant_one(w, t);
    checks++;
    if (w != 0) begin
      failures++;
      $display("FAIL add_winner: got %0d required 0", w);
    end
    #1;
    checks++;
    if (busy_o !== 1'b1) begin
      failures++;
      $display("FAIL add_busy_exec: got %b required 1", busy_o);
    end
    get_rsp();
    checks++;
    if (busy_o !== 1'b1) begin
      failures++;
      $display("FAIL add_busy_resp: got %b required 1", busy_o);
    end
    @(negedge clk_i);
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL add_busy_idle: got %b required 0", busy_o);
    end
  endtask

  task automatic test_back_to_back();
    int w0, t0, w1, t1;
    do_reset();
    drive_req(0, 3'b110, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    drive_req(1, 3'b111, 32'd5, 32'd7);
    grant_one(w0, t0);
    checks++;
    if (w0 != 0) begin
      failures++;
      $display("FAIL tie_first: got %0d required 0", w0);
    end
    get_rsp();
    grant_one(w1, t1);
    checks++;
    if (w1 != 1 || t1 != t0 + 3) begin
      failures++;
      $display("FAIL tie_second: winner %0d cycle %0d, required winner 1 cycle %0d",
               w1, t1, t0 + 3);
    end
    get_rsp();
  endtask

  task automatic test_mul();
    int w, t;
    drive_req(1, 3'b011, 32'h0001_0003, 32'h0000_0005);
    grant_one(w, t);
    get_rsp();
    drive_req(1, 3'b011, 32'hFFFF_FFFD, 32'd7);
    grant_one(w, t);
    get_rsp();
    drive_req(0, 3'b011, 32'h1234_5678, 32'h9ABC_DEF1);
    grant_one(w, t);
    get_rsp();
  endtask

  task automatic test_shift();
    int w, t;
    drive_req(0, 3'b100, 32'h8000_0000, 32'h0000_001F);
    grant_one(w, t);
    get_rsp();
    drive_req(0, 3'b101, 32'h0000_0001, 32'h0000_0024);
    grant_one(w, t);
    get_rsp();
    drive_req(0, 3'b010, 32'h0000_0010, 32'hFFFF_FFF0);
    grant_one(w, t);
    get_rsp();
    drive_req(1, 3'b000, 32'hFF00_FF00, 32'h0FF0_0FF0);
    grant_one(w, t);
    get_rsp();
  endtask

  task automatic test_stall();
    int w, t, hs;
    logic [W-1:0] d0;
    logic id0;
    drive_req(0, 3'b001, 32'd100, 32'd23);
    grant_one(w, t);
    rsp_ready_i = 1'b0;
    get_rsp();
    d0 = rsp_data_o;
    id0 = rsp_id_o;
    drive_req(0, 3'b111, 32'd50, 32'd8);
    drive_req(1, 3'b110, 32'h0000_FFFF, 32'hFFFF_0000);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_i);
      #1;
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_data_o !== d0 || rsp_id_o !== id0 || req_ready_o !== 2'b00) begin
        failures++;
        $display("FAIL stall_hold%0d: valid=%b data=%h id=%b ready=%b, required 1 %h %b 00",
                 k, rsp_valid_o, rsp_data_o, rsp_id_o, req_ready_o, d0, id0);
      end
    end
    rsp_ready_i = 1'b1;
    hs = cyc;
    @(negedge clk_i);
    #1;
    checks++;
    if (req_ready_o !== 2'b10) begin
      failures++;
      $display("FAIL stall_regrant: ready=%b, required 10 in cycle after handshake", req_ready_o);
    end
    grant_one(w, t);
    checks++;
    if (t != hs + 1 || w != 1) begin
      failures++;
      $display("FAIL stall_grant_cycle: winner %0d cycle %0d, required winner 1 cycle %0d",
               w, t, hs + 1);
    end
    req_valid_i = 2'b00;
    get_rsp();
  endtask

  task automatic test_mul_reset();
    int w, t;
    bit spurious;
    drive_req(0, 3'b011, 32'd9, 32'd9);
    grant_one(w, t);
    repeat (9) @(negedge clk_i);
    #1;
    checks++;
    if (busy_o !== 1'b1 || cyc != t + 10) begin
      failures++;
      $display("FAIL mul_busy: busy=%b cycle %0d, required 1 at cycle %0d", busy_o, cyc, t + 10);
    end
    rst_i       = 1'b0;
    req_valid_i = 2'b11;
    #1;
    checks++;
    if ({req_ready_o, rsp_valid_o, rsp_id_o, busy_o} !== 5'b0 || rsp_data_o !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs: ready=%b valid=%b id=%b busy=%b data=%h, required all 0",
               req_ready_o, rsp_valid_o, rsp_id_o, busy_o, rsp_data_o);
    end
    sb_q.delete();
    sb_t.delete();
    repeat (2) @(negedge clk_i);
    req_valid_i = 2'b00;
    rst_i       = 1'b1;
    spurious    = 1'b0;
    repeat (40) begin
      @(negedge clk_i);
      if (rsp_valid_o !== 1'b0) spurious = 1'b1;
    end
    checks++;
    if (spurious) begin
      failures++;
      $display("FAIL abort_no_rsp: rsp_valid_o rose after reset, required none");
    end
    drive_req(0, 3'b000, 32'hAAAA_5555, 32'h0F0F_F0F0);
    drive_req(1, 3'b001, 32'd1, 32'd2);
    grant_one(w, t);
    checks++;
    if (w != 0) begin
      failures++;
      $display("FAIL post_reset_tie: got %0d required 0", w);
    end
    get_rsp();
    grant_one(w, t);
    get_rsp();
  endtask

  initial begin
    rst_i       = 1'b0;
    req_valid_i = 2'b00;
    req_op_i    = '0;
    req_a_i     = '0;
    req_b_i     = '0;
    rsp_ready_i = 1'b1;
    test_reset();
    test_add();
    test_back_to_back();
    test_mul();
    test_shift();
    test_stall();
    test_mul_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Shares one ALU between two requesters (0: core issue stage, 1: debug/auxiliary port) using round-robin arbitration and sequences each operation to completion. Single-cycle ops finish in one execute cycle. MUL runs as an iterative shift-add over WIDTH cycles. Sits between the issue logic and the ALU datapath, consuming the 3-bit ALU control codes produced by the ALU control decoder.

## Interface
- WIDTH, 32, operand/result width; must be a power of two ≥ 8
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- req_valid_i  in  2  per-requester request valid (bit n = requester n)
- req_ready_o  out  2  per-requester accept; at most one bit high per cycle
- req_op_i  in  6  ALU control codes, [2:0] requester 0, [5:3] requester 1
- req_a_i  in  2*WIDTH  operand A, [WIDTH-1:0] requester 0
- req_b_i  in  2*WIDTH  operand B (sign-extended immediate for ADDI)
- rsp_valid_o  out  1  result valid
- rsp_ready_i  in  1  result consumed
- rsp_id_o  out  1  requester that owns the result
- rsp_data_o  out  WIDTH  result
- busy_o  out  1  high whenever state ≠ IDLE

## Operation
- Op codes: AND 000, ADD 001, ADDI 010, MUL 011, SRAI 100, SLL 101, XOR 110, SUB 111. All 8 codes are defined; there is no illegal op.
- FSM states: IDLE, EXEC, MUL, RESP.
- IDLE:
  - If any req_valid_i bit is set, grant one requester: req_ready_o[g]=1 combinationally that cycle.
  - Latch op, a, b and id at the clock edge.
  - Next state is MUL if op = 011, else EXEC.
- Arbitration:
  - Single valid: that requester wins.
  - Both valid: the requester ≠ last_grant wins.
  - last_grant updates on every grant and resets to 1, so requester 0 wins the first tie.
- EXEC: compute the result into the result register, then go to RESP.
- Arithmetic:
  - ADD, ADDI and SUB wrap modulo 2^WIDTH.
  - SLL and SRAI use shift amount b[log2(WIDTH)-1:0]. SRAI replicates a[WIDTH-1].
- MUL:
  - Iteration counter runs 0..WIDTH-1.
  - Each cycle: if multiplier bit 0 is set, add the multiplicand to the accumulator; shift the multiplicand left and the multiplier right.
  - Result is the low WIDTH bits of the product (signed and unsigned results are identical).
  - After the final iteration, go to RESP.
- RESP:
  - rsp_valid_o=1 with data and id held stable until rsp_ready_i=1; then go to IDLE.
  - No new request is accepted in the RESP→IDLE handoff cycle.
- Requesters may change payload or deassert valid freely until granted. Payload is sampled only in the grant cycle.
- Reset at any point aborts the in-flight op and produces no response.

## Timing
- Reset values:
  - All outputs 0: req_ready_o=00, rsp_valid_o=0, rsp_id_o=0, rsp_data_o=0, busy_o=0.
  - state=IDLE, last_grant=1, counter=0.
- Grant at edge T (ready high in cycle T):
  - Non-MUL: EXEC in cycle T+1; rsp_valid_o rises in cycle T+2.
  - MUL: MUL occupies cycles T+1..T+WIDTH; rsp_valid_o rises in cycle T+WIDTH+1.
- Handshake completes at the edge where rsp_valid_o && rsp_ready_i. Earliest next grant is the following cycle (IDLE).
- Back-to-back single-cycle throughput: one op per 3 cycles with rsp_ready_i tied high.
- req_ready_o is high only in IDLE.
- busy_o is registered state decode, with no combinational path from inputs.

## Structure
- Package alu_sched_pkg:
  - op-code localparams (ALU_AND … ALU_SUB)
  - state enum (IDLE, EXEC, MUL, RESP)
  - helper function for log2(WIDTH)
- Sub-module alu_mul_iter: iterative shift-add multiplier.
  - Ports: start, a, b, done, product.
  - Owns the counter and accumulator.
  - The scheduler FSM waits in MUL until done.
- Single-cycle result mux stays in alu_scheduler.

## Test plan
- Reset, then requester 0: ADD a=0xFFFFFFFF, b=1 → ready0 at T, rsp at T+2 with data=0x00000000, id=0, busy_o high T+1..T+2.
- Both requesters valid after reset (r0 XOR 0xF0F0F0F0^0x0F0F0F0F, r1 SUB 5−7) → r0 granted first with data=0xFFFFFFFF; r1 granted next with data=0xFFFFFFFE, id=1.
- Requester 1: MUL a=0x0001_0003, b=0x0000_0005 → rsp at T+33 (WIDTH=32) with data=0x0005_000F. Also MUL −3×7 → 0xFFFFFFEB.
- Requester 0: SRAI a=0x80000000, b=0x0000001F → 0xFFFFFFFF; SLL a=1, b=0x00000024 (shift 4) → 0x00000010.
- rsp_ready_i held low 5 cycles in RESP → data and id stable, no grant despite req_valid_i=11; grant occurs the cycle after the handshake.
- rst_i asserted in the 10th MUL cycle → all outputs 0 immediately, no response after release. The next request is served normally, and requester 0 wins the first tie again.
